// File: rtl/seq_match_monitor.sv
// -----------------------------------------------------------------------------
// seq_match_monitor
//
// Watches the Mealy match pulse Z of a serial sequence detector. While the
// monitor is running it counts matches in two ways: a saturating grand total
// and a saturating count for the current fixed-length window of WIN_LEN
// cycles. Every window close produces a report for the host, handed over with
// a valid/ack handshake. Alarm latches once any window reaches THRESH
// matches. Overrun latches when a window closes while the previous report has
// not been taken yet.
//
// Handshake (valid/ack): ReportValid rises one cycle after a window close and
// stays high with ReportCount stable until the host samples ReportAck=1 on a
// rising edge. An ack on the same edge as a close hands off the old report
// and loads the new one in one step, so ReportValid stays high with no
// overrun. An ack while ReportValid=0 has no effect. The handshake works in
// both IDLE and RUN.
//
// Ports:
//   CLK          in   clock, rising edge
//   Reset        in   asynchronous reset, active low
//   Z            in   match pulse from the detector
//   En           in   monitoring enable (IDLE <-> RUN)
//   Clear        in   synchronous clear of counts, report and flags
//   ReportAck    in   host acknowledge of the pending report
//   TotalCount   out  saturating count of all matches counted
//   WinCount     out  saturating count of matches in the open window
//   ReportValid  out  a closed-window report is pending
//   ReportCount  out  match count of the reported window
//   Alarm        out  sticky: some window reached THRESH
//   Overrun      out  sticky: a window closed while a report was pending
//   state_dbg    out  current FSM state (0 = IDLE, 1 = RUN)
// -----------------------------------------------------------------------------
module seq_match_monitor #(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16,
  parameter int THRESH  = 3
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Z,
  input  logic             En,
  input  logic             Clear,
  input  logic             ReportAck,
  output logic [CNT_W-1:0] TotalCount,
  output logic [CNT_W-1:0] WinCount,
  output logic             ReportValid,
  output logic [CNT_W-1:0] ReportCount,
  output logic             Alarm,
  output logic             Overrun,
  output logic             state_dbg
);

  localparam int               POS_W    = $clog2(WIN_LEN);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [POS_W-1:0] pos;

  logic             count_edge;   // a RUN edge with En=1: the window advances
  logic             counting;     // a count_edge that also carries a match
  logic             close_edge;   // last position of the window
  logic             leave_run;    // RUN edge with En=0: partial window dropped
  logic             load_report;  // close edge whose report slot is free
  logic [CNT_W-1:0] win_plus;     // WinCount after this edge's match, saturated

  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    // Clear leaves the FSM where it is.
    if (!Clear) begin
      case (state)
        IDLE:    if (En)  next_state = RUN;
        RUN:     if (!En) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Per-edge decode
  // ---------------------------------------------------------------------------
  always_comb begin
    count_edge  = (state == RUN) && En;
    counting    = count_edge && Z;
    close_edge  = count_edge && (pos == LAST_POS);
    leave_run   = (state == RUN) && !En;
    // The close-edge match belongs to the closing window, so the report is
    // taken from win_plus rather than from the registered WinCount.
    win_plus    = WinCount;
    if (counting && (WinCount != CNT_MAX)) begin
      win_plus = WinCount + CNT_W'(1);
    end
    load_report = close_edge && (!ReportValid || ReportAck);
  end

  // ---------------------------------------------------------------------------
  // Counters, report slot and sticky flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      TotalCount  <= '0;
      WinCount    <= '0;
      pos         <= '0;
      ReportValid <= 1'b0;
      ReportCount <= '0;
      Alarm       <= 1'b0;
      Overrun     <= 1'b0;
    end else if (Clear) begin
      TotalCount  <= '0;
      WinCount    <= '0;
      pos         <= '0;
      ReportValid <= 1'b0;
      ReportCount <= '0;
      Alarm       <= 1'b0;
      Overrun     <= 1'b0;
    end else begin
      if (counting && (TotalCount != CNT_MAX)) begin
        TotalCount <= TotalCount + CNT_W'(1);
      end

      if (close_edge || leave_run) begin
        WinCount <= '0;
        pos      <= '0;
      end else if (count_edge) begin
        WinCount <= win_plus;
        pos      <= pos + POS_W'(1);
      end

      if (counting && (win_plus >= THRESH_C)) begin
        Alarm <= 1'b1;
      end

      if (load_report) begin
        ReportCount <= win_plus;
        ReportValid <= 1'b1;
      end else if (close_edge) begin
        // Slot still busy: keep the old report, flag the lost window.
        Overrun <= 1'b1;
      end else if (ReportValid && ReportAck) begin
        ReportValid <= 1'b0;
      end
    end
  end

endmodule
